instruction_fetch: RTL and testbench

Fetch stage of the processor. It owns the program counter and drives the 4-bit address of the combinational 16-word × 16-bit program ROM. It registers the returned instruction and hands it to decode over a valid/ready handshake. Unconditional jumps are pre-decoded locally so that they redirect fetch without a bubble. Taken branches and other redirects arrive from execute and flush the stage.

---
 rtl/proc_pkg.sv | 28 ++
 rtl/fetch_predecode.sv | 22 ++
 rtl/instruction_fetch.sv | 77 +++++++
 tb/tb_instruction_fetch.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/proc_pkg.sv
// Shared processor definitions: opcode encodings, instruction field positions,
// default widths and the fetch-stage state encoding.
package proc_pkg;

   localparam int DEF_ADDR_W  = 4;
   localparam int DEF_INSTR_W = 16;

   localparam int OPC_HI = 15;
   localparam int OPC_LO = 12;
   localparam int TGT_HI = 11;
   localparam int TGT_LO = 8;

   localparam logic [3:0] OP_NOP  = 4'b0000;
   localparam logic [3:0] OP_LOAD = 4'b0001;
   localparam logic [3:0] OP_ADD  = 4'b0010;
   localparam logic [3:0] OP_SUB  = 4'b0011;
   localparam logic [3:0] OP_JMP  = 4'b1000;
   localparam logic [3:0] OP_SUBI = 4'b1011;
   localparam logic [3:0] OP_BR   = 4'b1100;
   localparam logic [3:0] OP_MOV  = 4'b1110;
   localparam logic [3:0] OP_OUT  = 4'b1111;

   typedef enum logic {
      S_IDLE = 1'b0,
      S_RUN  = 1'b1
   } state_t;

endpackage

// File: rtl/fetch_predecode.sv
// Combinational pre-decode of the word on the ROM bus: spots JMP and picks the
// next PC so unconditional jumps redirect fetch without a bubble.
module fetch_predecode
   import proc_pkg::*;
#(
   parameter int ADDR_W  = DEF_ADDR_W,
   parameter int INSTR_W = DEF_INSTR_W
) (
   input  logic [INSTR_W-1:0] instr,
   input  logic [ADDR_W-1:0]  pc,
   output logic               is_jmp,
   output logic [ADDR_W-1:0]  next_pc
);

   // Only the opcode and target fields matter here; the low bits are decode's business.
   logic unused_low_bits;
   assign unused_low_bits = ^instr[TGT_LO-1:0];

   assign is_jmp  = (instr[OPC_HI:OPC_LO] == OP_JMP);
   assign next_pc = is_jmp ? ADDR_W'(instr[TGT_HI:TGT_LO]) : pc + ADDR_W'(1);

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: owns the PC, drives the ROM address, registers the fetched word
// and offers it to decode. Execute redirects flush the stage.
module instruction_fetch
   import proc_pkg::*;
#(
   parameter int                ADDR_W   = DEF_ADDR_W,
   parameter int                INSTR_W  = DEF_INSTR_W,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   output logic [ADDR_W-1:0]  rom_addr,
   input  logic [INSTR_W-1:0] rom_instr,
   input  logic               redirect_valid,
   input  logic [ADDR_W-1:0]  redirect_target,
   output logic               if_valid,
   input  logic               if_ready,
   output logic [INSTR_W-1:0] if_instr,
   output logic [ADDR_W-1:0]  if_pc,
   output logic               running,
   output logic [15:0]        fetch_count
);

   state_t             state;
   logic [ADDR_W-1:0]  pc;
   logic               is_jmp;
   logic [ADDR_W-1:0]  next_pc;
   logic               capture;

   fetch_predecode #(
      .ADDR_W  (ADDR_W),
      .INSTR_W (INSTR_W)
   ) u_predecode (
      .instr   (rom_instr),
      .pc      (pc),
      .is_jmp  (is_jmp),
      .next_pc (next_pc)
   );

   // Handshake: a pair transfers on a rising edge where if_valid && if_ready;
   // once raised, if_valid and its pair hold until accepted or flushed by redirect.
   assign capture  = (state == S_RUN) && !redirect_valid && (!if_valid || if_ready);
   assign rom_addr = pc;
   assign running  = (state == S_RUN);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= S_IDLE;
         pc          <= RESET_PC;
         if_valid    <= 1'b0;
         if_instr    <= '0;
         if_pc       <= '0;
         fetch_count <= '0;
      end else begin
         // A redirect also swallows a start in the same cycle: state never moves on a redirect.
         if (redirect_valid) begin
            pc       <= redirect_target;
            if_valid <= 1'b0;
         end else begin
            if (state == S_IDLE && start) begin
               state <= S_RUN;
            end
            if (capture) begin
               if_instr    <= rom_instr;
               if_pc       <= pc;
               if_valid    <= 1'b1;
               fetch_count <= fetch_count + 16'd1;
               pc          <= next_pc;
            end else if (if_valid && if_ready) begin
               if_valid <= 1'b0;
            end
         end
      end
   end

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: behavioural ROM, expected {pc,instr}
// queue popped on every delivered handshake, plus point checks.
module tb_instruction_fetch;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic [3:0]  rom_addr;
   logic [15:0] rom_instr;
   logic        redirect_valid;
   logic [3:0]  redirect_target;
   logic        if_valid;
   logic        if_ready;
   logic [15:0] if_instr;
   logic [3:0]  if_pc;
   logic        running;
   logic [15:0] fetch_count;

   logic [15:0] rom [16];
   logic [19:0] exp_q[$];
   int          n_tests = 0;
   int          n_fail  = 0;

   assign rom_instr = rom[rom_addr];

   instruction_fetch dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .start           (start),
      .rom_addr        (rom_addr),
      .rom_instr       (rom_instr),
      .redirect_valid  (redirect_valid),
      .redirect_target (redirect_target),
      .if_valid        (if_valid),
      .if_ready        (if_ready),
      .if_instr        (if_instr),
      .if_pc           (if_pc),
      .running         (running),
      .fetch_count     (fetch_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic push(input int pc);
      exp_q.push_back({4'(pc), rom[pc]});
   endtask

   // Inputs were set just before the call, so the pair seen here is what the
   // next rising edge transfers; a redirect discards it.
   task automatic cyc();
      logic [19:0] e;
      if (if_valid && if_ready && !redirect_valid) begin
         n_tests++;
         assert (exp_q.size() > 0) else begin
            n_fail++;
            $error("FAIL sb_underflow: observed pc %0h instr %0h expected none", if_pc, if_instr);
         end
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("sb_pair", {12'h0, if_pc, if_instr}, {12'h0, e});
         end
      end
      @(negedge clk);
   endtask

   initial begin
      for (int i = 0; i < 16; i++) rom[i] = {8'h00, 4'(i), 4'h0};
      rst_n           = 1'b0;
      start           = 1'b0;
      redirect_valid  = 1'b0;
      redirect_target = 4'd0;
      if_ready        = 1'b0;

      // Power-on reset values
      @(negedge clk);
      chk("rst_rom_addr", rom_addr, 0);
      chk("rst_if_valid", if_valid, 0);
      chk("rst_running", running, 0);
      chk("rst_fetch_count", fetch_count, 0);
      rst_n = 1'b1;
      @(negedge clk);

      // Redirect in IDLE only loads the PC; start then fetches from the target
      redirect_valid  = 1'b1;
      redirect_target = 4'd7;
      cyc();
      chk("idle_redir_addr", rom_addr, 7);
      chk("idle_redir_running", running, 0);
      chk("idle_redir_valid", if_valid, 0);
      redirect_valid = 1'b0;
      start          = 1'b1;
      if_ready       = 1'b1;
      cyc();
      chk("start_running", running, 1);
      chk("start_no_capture", if_valid, 0);
      start = 1'b0;
      push(7); push(8); push(9);
      cyc();
      chk("first_pc_after_idle_redir", if_pc, 7);
      cyc(); cyc(); cyc();
      chk("count_before_reset", fetch_count, 4);

      // Asynchronous reset in the middle of a run
      rst_n = 1'b0;
      #1;
      chk("mid_rst_if_valid", if_valid, 0);
      chk("mid_rst_if_pc", if_pc, 0);
      chk("mid_rst_if_instr", if_instr, 0);
      chk("mid_rst_fetch_count", fetch_count, 0);
      chk("mid_rst_running", running, 0);
      chk("mid_rst_rom_addr", rom_addr, 0);
      @(negedge clk);
      rst_n = 1'b1;
      if_ready = 1'b1;

      // Idle with start low
      for (int i = 0; i < 10; i++) begin
         cyc();
         chk("idle_rom_addr", rom_addr, 0);
         chk("idle_if_valid", if_valid, 0);
      end

      // Linear fetch across the 15->0 wrap
      start = 1'b1;
      cyc();
      start = 1'b0;
      for (int i = 0; i < 17; i++) push(i % 16);
      for (int i = 0; i < 17; i++) cyc();
      chk("linear_count17", fetch_count, 17);
      chk("linear_wrap_pc", if_pc, 0);

      // Backpressure at pc 5
      for (int i = 1; i <= 5; i++) push(i);
      for (int i = 0; i < 5; i++) cyc();
      if_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         cyc();
         chk("stall_if_pc", if_pc, 5);
         chk("stall_if_instr", if_instr, rom[5]);
         chk("stall_count", fetch_count, 22);
      end
      if_ready = 1'b1;
      push(6);
      cyc();
      chk("after_stall_pc", if_pc, 6);

      // JMP at 11 back to 10, no bubbles
      rom[10] = 16'hF100;
      rom[11] = 16'b1000_1010_0000_0000;
      push(7); push(8); push(9); push(10); push(11); push(10); push(11);
      for (int i = 0; i < 8; i++) begin
         chk("jmp_no_gap", if_valid, 1);
         cyc();
      end
      chk("jmp_loop_pc", if_pc, 10);
      chk("jmp_loop_count", fetch_count, 31);

      // Redirect to 10 on the same edge a JMP to 3 is on the ROM bus
      rom[11]         = 16'h8300;
      redirect_valid  = 1'b1;
      redirect_target = 4'd10;
      cyc();
      chk("redir_jmp_bubble", if_valid, 0);
      chk("redir_jmp_count", fetch_count, 31);
      redirect_valid = 1'b0;
      push(10); push(11); push(3); push(4);
      cyc();
      chk("redir_beats_jmp_pc", if_pc, 10);
      cyc(); cyc(); cyc(); cyc();
      chk("jmp3_reach_pc5", if_pc, 5);

      // Redirect to 10 while stalled at pc 5
      if_ready = 1'b0;
      cyc();
      redirect_valid = 1'b1;
      cyc();
      chk("stall_redir_bubble", if_valid, 0);
      chk("stall_redir_count", fetch_count, 36);
      redirect_valid = 1'b0;
      if_ready       = 1'b1;
      cyc();
      chk("stall_redir_valid", if_valid, 1);
      chk("stall_redir_pc", if_pc, 10);
      push(10);
      cyc();
      chk("sb_drained", exp_q.size(), 0);
      chk("final_count", fetch_count, 38);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
